regid_encoder_16_4: RTL and testbench

Round-robin pending-register serializer: the encode-side counterpart to the register file's 4-to-16 read/write wordline decoders. It accumulates a 16-bit multi-hot vector of register write requests and emits them one at a time as a 4-bit register ID plus write strobe. The ID and strobe drive the register file's write port directly. It sits between write-back sources that flag registers in bulk (multi-cycle ops, load returns) and the single register-file write port.

---
 rtl/regid_encoder_16_4.sv | 73 +++++++
 tb/tb_regid_encoder_16_4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regid_encoder_16_4.sv
// Round-robin pending-register serializer: collects multi-hot write requests and
// presents them one at a time as a 4-bit register ID plus write strobe.
module regid_encoder_16_4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   input  logic [15:0] req_vec,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [3:0]  out_regID,
   output logic        out_writeReg,
   output logic [4:0]  pending_cnt
);

   logic [15:0] pending_q, pending_d;
   logic [15:0] set_v, clr_v;
   logic [3:0]  ptr_q, ptr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  sel, idx;
   logic        found, grant;

   // Scan from ptr upward with 4-bit wrap: first hit is the round-robin winner.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         idx = ptr_q + 4'(k);
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign out_valid    = |pending_q;
   assign out_regID    = sel;
   assign grant        = out_valid & out_ready;
   assign out_writeReg = grant;
   assign pending_cnt  = cnt_q;

   always_comb begin
      set_v     = req_valid ? req_vec : 16'h0000;
      clr_v     = '0;
      ptr_d     = ptr_q;
      if (grant) begin
         clr_v[sel] = 1'b1;
         ptr_d      = sel + 4'd1;
      end
      // Set is applied after clear so a same-cycle re-request survives its grant.
      pending_d = (pending_q & ~clr_v) | set_v;
      if (flush) begin
         pending_d = '0;
         ptr_d     = '0;
      end
      cnt_d = '0;
      for (int i = 0; i < 16; i++) cnt_d = cnt_d + 5'(pending_d[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_regid_encoder_16_4.sv
// Bench for regid_encoder_16_4: set-based reference model checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_regid_encoder_16_4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic [15:0] req_vec;
   logic        out_ready;
   logic        out_valid;
   logic [3:0]  out_regID;
   logic        out_writeReg;
   logic [4:0]  pending_cnt;

   int n_cmp = 0;
   int n_err = 0;

   regid_encoder_16_4 dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
      .req_vec(req_vec), .out_ready(out_ready), .out_valid(out_valid),
      .out_regID(out_regID), .out_writeReg(out_writeReg), .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a set of pending registers and a search start index.
   bit m_pend [16];
   int m_ptr;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 16; i++) if (m_pend[i]) c++;
      return c;
   endfunction

   // Lowest pending index at or above ptr, otherwise lowest pending overall; -1 if none.
   function automatic int m_pick();
      for (int i = m_ptr; i < 16; i++) if (m_pend[i]) return i;
      for (int i = 0; i < m_ptr; i++) if (m_pend[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || (rst_n && flush)) begin
         for (int i = 0; i < 16; i++) m_pend[i] <= 1'b0;
         m_ptr <= 0;
      end else begin
         automatic int  p = m_pick();
         automatic bit  nxt [16];
         for (int i = 0; i < 16; i++) nxt[i] = m_pend[i];
         if (p >= 0 && out_ready) begin
            nxt[p] = 1'b0;
            m_ptr <= (p + 1) % 16;
         end
         if (req_valid)
            for (int i = 0; i < 16; i++) if (req_vec[i]) nxt[i] = 1'b1;
         for (int i = 0; i < 16; i++) m_pend[i] <= nxt[i];
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      automatic int p = m_pick();
      check("mdl_valid", int'(out_valid), (p >= 0) ? 1 : 0);
      check("mdl_regID", int'(out_regID), (p >= 0) ? p : 0);
      check("mdl_wr",    int'(out_writeReg), (p >= 0 && out_ready) ? 1 : 0);
      check("mdl_cnt",   int'(pending_cnt), m_count());
   end

   task automatic drive(input logic rv, input logic [15:0] v, input logic rdy, input logic fl);
      req_valid = rv; req_vec = v; out_ready = rdy; flush = fl;
   endtask

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic chk_out(input string name, input int v, input int id, input int wr, input int c);
      check({name, "_valid"}, int'(out_valid), v);
      check({name, "_id"},    int'(out_regID), id);
      check({name, "_wr"},    int'(out_writeReg), wr);
      check({name, "_cnt"},   int'(pending_cnt), c);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 16'h0000, 0, 0);
      repeat (2) tick();
      chk_out("rst_hold", 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("idle", 0, 0, 0, 0);
      end

      // Burst drain: 0,5,10,15 then empty.
      drive(1, 16'h8421, 1, 0);
      tick(); chk_out("drain0", 1, 0, 1, 4);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("drain5", 1, 5, 1, 3);
      tick(); chk_out("drain10", 1, 10, 1, 2);
      tick(); chk_out("drain15", 1, 15, 1, 1);
      tick(); chk_out("drain_end", 0, 0, 0, 0);

      // Wrap: grant 9 moves ptr to 10; with {0,9} pending nothing is >=10, so 0 wins first.
      drive(1, 16'h0200, 0, 0);
      tick(); chk_out("rr_load9", 1, 9, 0, 1);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("rr_gnt9", 0, 0, 0, 0);
      drive(1, 16'h0201, 0, 0);
      tick(); chk_out("rr_first", 1, 0, 0, 2);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("rr_second", 1, 9, 1, 1);
      tick(); chk_out("rr_end", 0, 0, 0, 0);

      // Backpressure and merge.
      drive(1, 16'h0003, 0, 0);
      tick(); chk_out("bp1", 1, 0, 0, 2);
      tick(); chk_out("bp2", 1, 0, 0, 2);
      drive(0, 16'h0000, 1, 0);
      #1 chk_out("bp_rdy", 1, 0, 1, 2);
      tick(); chk_out("bp_g1", 1, 1, 1, 1);
      tick(); chk_out("bp_end", 0, 0, 0, 0);

      // Set wins over same-cycle clear.
      drive(1, 16'h0008, 0, 0);
      tick(); chk_out("sw_load", 1, 3, 0, 1);
      drive(1, 16'h0008, 1, 0);
      #1 chk_out("sw_gnt", 1, 3, 1, 1);
      tick(); chk_out("sw_kept", 1, 3, 1, 1);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("sw_end", 0, 0, 0, 0);

      // Flush beats set and grant.
      drive(1, 16'hFFFF, 0, 0);
      tick(); chk_out("fl_full", 1, 4, 0, 16);
      drive(1, 16'h0001, 1, 1);
      tick(); chk_out("fl_clr", 0, 0, 0, 0);
      drive(0, 16'h0000, 0, 0);
      tick(); chk_out("fl_after", 0, 0, 0, 0);

      // Asynchronous reset between edges in the middle of a drain.
      drive(1, 16'h00F0, 0, 0);
      tick(); chk_out("ar_load", 1, 4, 0, 4);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("ar_mid", 1, 5, 1, 3);
      #2 rst_n = 1'b0;
      #1 chk_out("ar_async", 0, 0, 0, 0);
      tick(); chk_out("ar_held", 0, 0, 0, 0);
      rst_n = 1'b1;
      drive(1, 16'h4000, 1, 0);
      tick(); chk_out("ar_first", 1, 14, 1, 1);
      drive(0, 16'h0000, 1, 0);
      tick(); chk_out("ar_end", 0, 0, 0, 0);

      // Random mix against the model only.
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 31) == 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
